// File: rtl/rvvi_text_pkg.sv
// rvvi_text_pkg
// Shared definitions for the RVVI text trace encoder: ASCII constants, the
// encoder state enum and small character-formatting helpers.
// Optional feature macro: RVVI_TEXT_CSR_EN (adds the CSR field states).
// No ports (package).

package rvvi_text_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_NL    = 8'h0a;
   localparam logic [7:0] CH_0     = 8'h30;

   // One state per emitted field; each field state also owns its leading space.
   typedef enum logic [3:0] {
      IDLE,
      HART_KEY,
      HART_NUM,
      EOL_H,
      EVT_KEY,
      PC,
      INSN,
      X_KEY,
      X_IDX,
      X_DATA,
`ifdef RVVI_TEXT_CSR_EN
      C_KEY,
      C_IDX,
      C_DATA,
`endif
      EOL
   } state_t;

   // Lowercase hex digit for a nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] nibble);
      if (nibble < 4'd10)
         return CH_0 + {4'h0, nibble};
      else
         return 8'h57 + {4'h0, nibble};
   endfunction

   // ASCII digit for a decimal digit value 0..9.
   function automatic logic [7:0] dec_char(input logic [3:0] digit);
      return CH_0 + {4'h0, digit};
   endfunction

   // Split 0..31 into {tens, ones, ntens}; ntens is set when a tens digit
   // must be printed (no leading zero for single-digit values).
   function automatic logic [8:0] dec2(input logic [4:0] value);
      logic [3:0] tens;
      logic [3:0] ones;
      if (value >= 5'd30) begin
         tens = 4'd3;
         ones = 4'(value - 5'd30);
      end else if (value >= 5'd20) begin
         tens = 4'd2;
         ones = 4'(value - 5'd20);
      end else if (value >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(value - 5'd10);
      end else begin
         tens = 4'd0;
         ones = value[3:0];
      end
      return {tens, ones, (value >= 5'd10)};
   endfunction

endpackage

// File: rtl/rvvi_text_hex_ser.sv
// rvvi_text_hex_ser
// Hex digit serializer shared by every hex field of the trace line. A load
// captures an up-to-64-bit value and its digit count; each shift pulse then
// advances to the next digit, most significant first.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture load_value / load_digits (wins over shift)
//   load_value      value to print, right-aligned
//   load_digits     number of hex digits to print (1..16)
//   shift           current digit consumed, advance to the next
//   digit_char      lowercase ASCII of the current digit
//   last            current digit is the final one of the field

module rvvi_text_hex_ser
   import rvvi_text_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [63:0] load_value,
   input  logic [4:0]  load_digits,
   input  logic        shift,
   output logic [7:0]  digit_char,
   output logic        last
);

   logic [63:0] shift_reg;
   logic [4:0]  remaining;
   logic [6:0]  align;

   // Left-justify the value so the first digit always sits in the top nibble.
   assign align = 7'd64 - {load_digits, 2'b00};

   // Shift register walks the digits MSB-first; remaining tracks how many are
   // left so the encoder knows when the field ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= 64'd0;
         remaining <= 5'd0;
      end else if (load) begin
         shift_reg <= load_value << align;
         remaining <= load_digits;
      end else if (shift && (remaining != 5'd0)) begin
         shift_reg <= {shift_reg[59:0], 4'h0};
         remaining <= remaining - 5'd1;
      end
   end

   assign digit_char = hex_char(shift_reg[63:60]);
   assign last       = (remaining == 5'd1);

endmodule

// File: rtl/rvvi_text_encoder.sv
// rvvi_text_encoder
// Turns RVVI retirement events into the RVVI text trace format, one ASCII
// byte per transfer:
//   "HART <d>\n"  (when the hart changes or after reset)
//   "RET|TRAP <pc> <insn>[ X <idx> <data>][ C <csr> <data>]\n"
// Optional feature macro: RVVI_TEXT_CSR_EN adds the C field and its ports.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   evt_valid / evt_ready      event handshake
//   evt_trap, evt_hart         TRAP vs RET key, hart id 0..15
//   evt_pc, evt_insn           retired PC and instruction word
//   evt_x_we/idx/data          GPR write (x0 writes are suppressed)
//   evt_c_we/idx/data          CSR write (RVVI_TEXT_CSR_EN only)
//   tx_data / tx_valid / tx_ready   byte stream handshake

module rvvi_text_encoder
   import rvvi_text_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int INSN_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evt_valid,
   output logic              evt_ready,
   input  logic              evt_trap,
   input  logic [3:0]        evt_hart,
   input  logic [XLEN-1:0]   evt_pc,
   input  logic [INSN_W-1:0] evt_insn,
   input  logic              evt_x_we,
   input  logic [4:0]        evt_x_idx,
   input  logic [XLEN-1:0]   evt_x_data,
`ifdef RVVI_TEXT_CSR_EN
   input  logic              evt_c_we,
   input  logic [11:0]       evt_c_idx,
   input  logic [XLEN-1:0]   evt_c_data,
`endif
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam logic [4:0] DATA_DIGITS = 5'(XLEN / 4);
   localparam logic [4:0] INSN_DIGITS = 5'(INSN_W / 4);

   state_t            state;
   state_t            state_next;
   logic [4:0]        cnt;
   logic              xfer;
   logic              accept;
   logic              need_hart;
   logic              field_done;

   logic              trap_q;
   logic [3:0]        hart_q;
   logic [XLEN-1:0]   pc_q;
   logic [INSN_W-1:0] insn_q;
   logic              x_we_q;
   logic [4:0]        x_idx_q;
   logic [XLEN-1:0]   x_data_q;
   logic              hart_seen;
   logic [3:0]        last_hart;
`ifdef RVVI_TEXT_CSR_EN
   logic              c_we_q;
   logic [11:0]       c_idx_q;
   logic [XLEN-1:0]   c_data_q;
`endif

   logic [8:0]        hart_dec;
   logic [8:0]        xidx_dec;
   logic              in_hex;
   logic              ser_load;
   logic [63:0]       ser_value;
   logic [4:0]        ser_digits;
   logic              ser_shift;
   logic [7:0]        ser_char;
   logic              ser_last;

   assign xfer      = tx_valid && tx_ready;
   assign accept    = evt_valid && evt_ready;
   assign need_hart = !hart_seen || (evt_hart != last_hart);
   assign evt_ready = (state == IDLE);
   assign hart_dec  = dec2({1'b0, hart_q});
   assign xidx_dec  = dec2(x_idx_q);

   // State register; reset abandons any partial line at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Character counter: restarts at every field boundary and steps on each
   // accepted byte, so it indexes keys and decimal digits MSB-first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 5'd0;
      else if (state_next != state)
         cnt <= 5'd0;
      else if (xfer)
         cnt <= cnt + 5'd1;
   end

   // Event capture and hart tracking; clearing hart_seen on reset forces the
   // first line after reset to re-announce its hart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q    <= 1'b0;
         hart_q    <= 4'd0;
         pc_q      <= '0;
         insn_q    <= '0;
         x_we_q    <= 1'b0;
         x_idx_q   <= 5'd0;
         x_data_q  <= '0;
         hart_seen <= 1'b0;
         last_hart <= 4'd0;
`ifdef RVVI_TEXT_CSR_EN
         c_we_q    <= 1'b0;
         c_idx_q   <= 12'd0;
         c_data_q  <= '0;
`endif
      end else if (accept) begin
         trap_q    <= evt_trap;
         hart_q    <= evt_hart;
         pc_q      <= evt_pc;
         insn_q    <= evt_insn;
         x_we_q    <= evt_x_we && (evt_x_idx != 5'd0);
         x_idx_q   <= evt_x_idx;
         x_data_q  <= evt_x_data;
         hart_seen <= 1'b1;
         last_hart <= evt_hart;
`ifdef RVVI_TEXT_CSR_EN
         c_we_q    <= evt_c_we;
         c_idx_q   <= evt_c_idx;
         c_data_q  <= evt_c_data;
`endif
      end
   end

   // Field-complete detection: true while the byte on tx_data is the last
   // one of the current field. Hex fields defer to the serializer.
   always_comb begin
      field_done = 1'b0;
      in_hex     = 1'b0;
      case (state)
         HART_KEY: field_done = (cnt == 5'd4);
         HART_NUM: field_done = hart_dec[0] ? (cnt == 5'd1) : (cnt == 5'd0);
         EOL_H:    field_done = 1'b1;
         EVT_KEY:  field_done = trap_q ? (cnt == 5'd3) : (cnt == 5'd2);
         X_KEY:    field_done = (cnt == 5'd1);
         X_IDX:    field_done = xidx_dec[0] ? (cnt == 5'd2) : (cnt == 5'd1);
`ifdef RVVI_TEXT_CSR_EN
         C_KEY:    field_done = (cnt == 5'd1);
         C_IDX, C_DATA,
`endif
         PC, INSN, X_DATA: begin
            in_hex     = 1'b1;
            field_done = (cnt != 5'd0) && ser_last;
         end
         EOL:      field_done = 1'b1;
         default:  field_done = 1'b0;
      endcase
   end

   // Next-state logic: advance one field when its last byte is accepted.
   // Optional X and C fields are skipped when no write is present.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept) state_next = need_hart ? HART_KEY : EVT_KEY;
         HART_KEY: if (xfer && field_done) state_next = HART_NUM;
         HART_NUM: if (xfer && field_done) state_next = EOL_H;
         EOL_H:    if (xfer && field_done) state_next = EVT_KEY;
         EVT_KEY:  if (xfer && field_done) state_next = PC;
         PC:       if (xfer && field_done) state_next = INSN;
         INSN: begin
            if (xfer && field_done) begin
               if (x_we_q)
                  state_next = X_KEY;
`ifdef RVVI_TEXT_CSR_EN
               else if (c_we_q)
                  state_next = C_KEY;
`endif
               else
                  state_next = EOL;
            end
         end
         X_KEY:    if (xfer && field_done) state_next = X_IDX;
         X_IDX:    if (xfer && field_done) state_next = X_DATA;
         X_DATA: begin
            if (xfer && field_done) begin
`ifdef RVVI_TEXT_CSR_EN
               state_next = c_we_q ? C_KEY : EOL;
`else
               state_next = EOL;
`endif
            end
         end
`ifdef RVVI_TEXT_CSR_EN
         C_KEY:    if (xfer && field_done) state_next = C_IDX;
         C_IDX:    if (xfer && field_done) state_next = C_DATA;
         C_DATA:   if (xfer && field_done) state_next = EOL;
`endif
         EOL:      if (xfer && field_done) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Serializer control: load the next hex field as its state is entered, so
   // the value is ready once the leading space has gone out.
   always_comb begin
      ser_load   = 1'b0;
      ser_value  = 64'd0;
      ser_digits = 5'd0;
      if (state_next != state) begin
         case (state_next)
            PC: begin
               ser_load   = 1'b1;
               ser_value  = 64'(pc_q);
               ser_digits = DATA_DIGITS;
            end
            INSN: begin
               ser_load   = 1'b1;
               ser_value  = 64'(insn_q);
               ser_digits = INSN_DIGITS;
            end
            X_DATA: begin
               ser_load   = 1'b1;
               ser_value  = 64'(x_data_q);
               ser_digits = DATA_DIGITS;
            end
`ifdef RVVI_TEXT_CSR_EN
            C_IDX: begin
               ser_load   = 1'b1;
               ser_value  = 64'(c_idx_q);
               ser_digits = 5'd3;
            end
            C_DATA: begin
               ser_load   = 1'b1;
               ser_value  = 64'(c_data_q);
               ser_digits = DATA_DIGITS;
            end
`endif
            default: begin
               ser_load   = 1'b0;
               ser_value  = 64'd0;
               ser_digits = 5'd0;
            end
         endcase
      end
   end

   assign ser_shift = xfer && in_hex && (cnt != 5'd0);

   rvvi_text_hex_ser u_hex_ser (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (ser_load),
      .load_value  (ser_value),
      .load_digits (ser_digits),
      .shift       (ser_shift),
      .digit_char  (ser_char),
      .last        (ser_last)
   );

   // Output decode: every non-idle state presents a byte, and the byte depends
   // only on registered state, so it holds steady while the sink stalls.
   always_comb begin
      tx_valid = (state != IDLE);
      tx_data  = 8'h00;
      case (state)
         HART_KEY: begin
            case (cnt)
               5'd0:    tx_data = "H";
               5'd1:    tx_data = "A";
               5'd2:    tx_data = "R";
               5'd3:    tx_data = "T";
               default: tx_data = CH_SPACE;
            endcase
         end
         HART_NUM: tx_data = ((cnt == 5'd0) && hart_dec[0]) ? dec_char(hart_dec[8:5])
                                                            : dec_char(hart_dec[4:1]);
         EOL_H, EOL: tx_data = CH_NL;
         EVT_KEY: begin
            if (trap_q) begin
               case (cnt)
                  5'd0:    tx_data = "T";
                  5'd1:    tx_data = "R";
                  5'd2:    tx_data = "A";
                  default: tx_data = "P";
               endcase
            end else begin
               case (cnt)
                  5'd0:    tx_data = "R";
                  5'd1:    tx_data = "E";
                  default: tx_data = "T";
               endcase
            end
         end
         X_KEY: tx_data = (cnt == 5'd0) ? CH_SPACE : "X";
         X_IDX: begin
            if (cnt == 5'd0)
               tx_data = CH_SPACE;
            else if ((cnt == 5'd1) && xidx_dec[0])
               tx_data = dec_char(xidx_dec[8:5]);
            else
               tx_data = dec_char(xidx_dec[4:1]);
         end
`ifdef RVVI_TEXT_CSR_EN
         C_KEY: tx_data = (cnt == 5'd0) ? CH_SPACE : "C";
         C_IDX, C_DATA,
`endif
         PC, INSN, X_DATA: tx_data = (cnt == 5'd0) ? CH_SPACE : ser_char;
         default: tx_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_rvvi_text_encoder.sv
// tb_rvvi_text_encoder
// Scoreboard bench for rvvi_text_encoder: each event pushes its hand-written
// expected text into a byte queue; an independent monitor pops one byte per
// accepted transfer and compares. Also checks reset values, first-byte
// latency, bubble-free streaming, stall stability and mid-line reset.
// Define RVVI_TEXT_CSR_EN to include the CSR field scenario.

module tb_rvvi_text_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_trap;
   logic [3:0]  evt_hart;
   logic [31:0] evt_pc;
   logic [31:0] evt_insn;
   logic        evt_x_we;
   logic [4:0]  evt_x_idx;
   logic [31:0] evt_x_data;
   logic        evt_c_we;
   logic [11:0] evt_c_idx;
   logic [31:0] evt_c_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic [7:0]  exp_q[$];
   int          n_compared   = 0;
   int          n_mismatched = 0;
   int          pop_count    = 0;
   bit          bp_en        = 1'b0;

   always #5 clk = ~clk;

   rvvi_text_encoder #(.XLEN(32), .INSN_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_trap   (evt_trap),
      .evt_hart   (evt_hart),
      .evt_pc     (evt_pc),
      .evt_insn   (evt_insn),
      .evt_x_we   (evt_x_we),
      .evt_x_idx  (evt_x_idx),
      .evt_x_data (evt_x_data),
`ifdef RVVI_TEXT_CSR_EN
      .evt_c_we   (evt_c_we),
      .evt_c_idx  (evt_c_idx),
      .evt_c_data (evt_c_data),
`endif
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   // Single comparison point: bumps the counters and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Sink: random 30% stalls when backpressure is enabled, else always ready.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every accepted byte and checks that a
   // stalled byte stays valid and unchanged into the next cycle.
   initial begin
      logic       stall_prev;
      logic [7:0] stall_data;
      logic [7:0] exp_byte;
      stall_prev = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (stall_prev) begin
               checkOutput("stall_valid", 64'(tx_valid), 64'd1);
               checkOutput("stall_data", 64'(tx_data), 64'(stall_data));
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_compared++;
                  n_mismatched++;
                  $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", tx_data);
               end else begin
                  exp_byte = exp_q.pop_front();
                  checkOutput("stream_byte", 64'(tx_data), 64'(exp_byte));
               end
               pop_count++;
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   // Offer one event, queue its expected text and follow it through. A
   // nonzero abort_after pulses reset once that many bytes have gone out.
   task automatic applyStimulus(input string name, input logic trap, input logic [3:0] hart,
                                input logic [31:0] pc, input logic [31:0] insn,
                                input logic x_we, input logic [4:0] x_idx,
                                input logic [31:0] x_data, input logic c_we,
                                input logic [11:0] c_idx, input logic [31:0] c_data,
                                input string expected, input bit backpressure,
                                input int abort_after);
      int cycles;
      int start_pop;
      bit ok;
      bit ready_glitch;
      for (int i = 0; i < expected.len(); i++) exp_q.push_back(expected[i]);
      bp_en = backpressure;
      @(posedge clk);
      #1;
      evt_valid  = 1'b1;
      evt_trap   = trap;
      evt_hart   = hart;
      evt_pc     = pc;
      evt_insn   = insn;
      evt_x_we   = x_we;
      evt_x_idx  = x_idx;
      evt_x_data = x_data;
      evt_c_we   = c_we;
      evt_c_idx  = c_idx;
      evt_c_data = c_data;
      ok = 1'b0;
      cycles = 0;
      while (!ok && cycles < 100) begin
         @(negedge clk);
         if (evt_ready) ok = 1'b1;
         cycles++;
      end
      if (!ok) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s_accept: got evt_ready=0 for 100 cycles, expected 1", name);
         evt_valid = 1'b0;
         exp_q.delete();
         bp_en = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
      start_pop = pop_count - 0;
      @(negedge clk);
      #1;
      cycles = 1;
      checkOutput({name, "_first_latency"}, 64'(tx_valid), 64'd1);

      if (abort_after > 0) begin
         while ((pop_count - start_pop) < abort_after && cycles < 2000) begin
            @(negedge clk);
            #1;
            cycles++;
         end
         #2;
         rst_n = 1'b0;
         #1;
         checkOutput({name, "_async_tx_valid"}, 64'(tx_valid), 64'd0);
         checkOutput({name, "_async_evt_ready"}, 64'(evt_ready), 64'd1);
         exp_q.delete();
         bp_en = 1'b0;
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end

      ready_glitch = 1'b0;
      while (exp_q.size() != 0 && cycles < 2000) begin
         if (evt_ready) ready_glitch = 1'b1;
         @(negedge clk);
         #1;
         cycles++;
      end
      if (exp_q.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s_drain: got %0d bytes left after 2000 cycles, expected 0",
                  name, exp_q.size());
         exp_q.delete();
      end
      checkOutput({name, "_evt_ready_busy"}, 64'(ready_glitch), 64'd0);
      if (!backpressure)
         checkOutput({name, "_cycles"}, 64'(cycles), 64'(expected.len()));
      bp_en = 1'b0;
      @(negedge clk);
      #1;
      checkOutput({name, "_ready_return"}, 64'(evt_ready), 64'd1);
   endtask

   // Global time bound so the bench can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      evt_valid  = 1'b0;
      evt_trap   = 1'b0;
      evt_hart   = 4'd0;
      evt_pc     = 32'd0;
      evt_insn   = 32'd0;
      evt_x_we   = 1'b0;
      evt_x_idx  = 5'd0;
      evt_x_data = 32'd0;
      evt_c_we   = 1'b0;
      evt_c_idx  = 12'd0;
      evt_c_data = 32'd0;
      #12;
      checkOutput("reset_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("reset_tx_data", 64'(tx_data), 64'h00);
      checkOutput("reset_evt_ready", 64'(evt_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("first", 1'b0, 4'd0, 32'h80000000, 32'h00000013, 1'b0, 5'd0, 32'd0,
                    1'b0, 12'd0, 32'd0, "HART 0\nRET 80000000 00000013\n", 1'b0, 0);
      applyStimulus("xwrite", 1'b0, 4'd0, 32'h80000004, 32'h00a00093, 1'b1, 5'd1, 32'h0000000a,
                    1'b0, 12'd0, 32'd0, "RET 80000004 00a00093 X 1 0000000a\n", 1'b0, 0);
      applyStimulus("trap_hart", 1'b1, 4'd11, 32'h80000100, 32'h00000073, 1'b1, 5'd0, 32'h12345678,
                    1'b0, 12'd0, 32'd0, "HART 11\nTRAP 80000100 00000073\n", 1'b0, 0);
      applyStimulus("backpressure", 1'b0, 4'd0, 32'h80000004, 32'h00a00093, 1'b1, 5'd1, 32'h0000000a,
                    1'b0, 12'd0, 32'd0, "HART 0\nRET 80000004 00a00093 X 1 0000000a\n", 1'b1, 0);
      applyStimulus("abort", 1'b0, 4'd0, 32'h80000008, 32'h00000013, 1'b0, 5'd0, 32'd0,
                    1'b0, 12'd0, 32'd0, "RET 80000008 00000013\n", 1'b0, 5);
      applyStimulus("after_reset", 1'b0, 4'd0, 32'h80000008, 32'h00000013, 1'b0, 5'd0, 32'd0,
                    1'b0, 12'd0, 32'd0, "HART 0\nRET 80000008 00000013\n", 1'b0, 0);
      applyStimulus("two_digit", 1'b0, 4'd15, 32'hdeadbeef, 32'hfff00f0f, 1'b1, 5'd31, 32'hcafe0001,
                    1'b0, 12'd0, 32'd0, "HART 15\nRET deadbeef fff00f0f X 31 cafe0001\n", 1'b0, 0);
`ifdef RVVI_TEXT_CSR_EN
      applyStimulus("csr", 1'b0, 4'd15, 32'h80000000, 32'h00000013, 1'b0, 5'd0, 32'd0,
                    1'b1, 12'h300, 32'h00001800, "RET 80000000 00000013 C 300 00001800\n", 1'b0, 0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
